// File: rtl/pe_dot_issue_ctrl.sv
// pe_dot_issue_ctrl
// Issue controller for the packed 4x DSP dot-product PE. Accepts one job
// descriptor per output tile, gates the operand chunk stream into the
// multiplier array, tags each chunk with first/last accumulator markers,
// and delays those tags by the multiplier latency so they line up with the
// packed multiplier outputs. Output-buffer credits are tracked so a job only
// starts when its result is guaranteed a landing slot downstream.

module pe_dot_issue_ctrl #(
    parameter int DOT_LATENCY = 3,
    parameter int MAX_CHUNKS  = 256,
    parameter int CREDITS     = 4,
    parameter int CW          = $clog2(MAX_CHUNKS),
    localparam int CRW        = $clog2(CREDITS + 1)
) (
    input  logic           clock,
    input  logic           reset,

    input  logic           i_job_valid,
    input  logic [CW-1:0]  i_job_chunks_m1,
    output logic           o_job_ready,

    input  logic           i_op_valid,
    output logic           o_op_ready,

    output logic           o_issue,
    output logic           o_issue_first,
    output logic           o_issue_last,

    output logic           o_mult_valid,
    output logic           o_mult_first,
    output logic           o_mult_last,

    input  logic           i_credit_return,
    output logic [CRW-1:0] o_credits,

    output logic           o_busy,
    output logic           o_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CRW-1:0] CREDITS_FULL = CRW'(CREDITS);

    state_t                 r_state;
    logic [CW-1:0]          r_chunkCnt;
    logic [CW-1:0]          r_chunksM1;
    logic                   r_jobReady;
    logic                   r_opReady;
    logic [CRW-1:0]         r_credits;
    logic                   r_err;
    logic [DOT_LATENCY-1:0] r_pipeValid;
    logic [DOT_LATENCY-1:0] r_pipeFirst;
    logic [DOT_LATENCY-1:0] r_pipeLast;

    logic                   w_jobAccept;
    logic                   w_opAccept;
    logic                   w_firstBeat;
    logic                   w_lastBeat;
    logic                   w_creditFull;
    logic                   w_errSet;
    logic [CRW-1:0]         w_creditsNext;

    // Handshakes and chunk tags; ready signals come straight from registers so
    // there is never a combinational path from a valid input to a ready output.
    assign w_jobAccept  = i_job_valid & r_jobReady;
    assign w_opAccept   = i_op_valid & r_opReady;
    assign w_firstBeat  = (r_chunkCnt == '0);
    assign w_lastBeat   = (r_chunkCnt == r_chunksM1);
    assign w_creditFull = (r_credits == CREDITS_FULL);
    assign w_errSet     = i_credit_return & w_creditFull;

    assign o_job_ready   = r_jobReady;
    assign o_op_ready    = r_opReady;
    assign o_issue       = w_opAccept;
    assign o_issue_first = w_opAccept & w_firstBeat;
    assign o_issue_last  = w_opAccept & w_lastBeat;

    assign o_mult_valid  = r_pipeValid[DOT_LATENCY-1];
    assign o_mult_first  = r_pipeFirst[DOT_LATENCY-1];
    assign o_mult_last   = r_pipeLast[DOT_LATENCY-1];

    assign o_credits     = r_credits;
    assign o_err         = r_err;
    assign o_busy        = (r_state != IDLE) | (|r_pipeValid);

    // Next credit count: an accept and a return in the same cycle cancel out,
    // and a return with every slot already free saturates instead of wrapping.
    always_comb begin
        w_creditsNext = r_credits;
        case ({w_jobAccept, i_credit_return})
            2'b10:   w_creditsNext = r_credits - 1'b1;
            2'b01:   if (!w_creditFull) w_creditsNext = r_credits + 1'b1;
            default: w_creditsNext = r_credits;
        endcase
    end

    // Credit counter and sticky over-return error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_credits <= CREDITS_FULL;
            r_err     <= 1'b0;
        end else begin
            r_credits <= w_creditsNext;
            r_err     <= r_err | w_errSet;
        end
    end

    // Job FSM with registered ready outputs; job_ready looks ahead at the next
    // credit count so a freed slot opens the door on the very next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_chunkCnt <= '0;
            r_chunksM1 <= '0;
            r_jobReady <= 1'b1;
            r_opReady  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_jobAccept) begin
                        r_chunksM1 <= i_job_chunks_m1;
                        r_chunkCnt <= '0;
                        r_state    <= RUN;
                        r_jobReady <= 1'b0;
                        r_opReady  <= 1'b1;
                    end else begin
                        r_jobReady <= (w_creditsNext != '0);
                        r_opReady  <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_opAccept) begin
                        r_chunkCnt <= r_chunkCnt + 1'b1;
                        if (w_lastBeat) begin
                            r_state    <= IDLE;
                            r_opReady  <= 1'b0;
                            r_jobReady <= (w_creditsNext != '0);
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_jobReady <= 1'b0;
                    r_opReady  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running tag delay line matching the multiplier depth; it never
    // stalls, and tags ride in already qualified by the issue strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pipeValid <= '0;
            r_pipeFirst <= '0;
            r_pipeLast  <= '0;
        end else begin
            r_pipeValid[0] <= o_issue;
            r_pipeFirst[0] <= o_issue_first;
            r_pipeLast[0]  <= o_issue_last;
            for (int i = 1; i < DOT_LATENCY; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                r_pipeFirst[i] <= r_pipeFirst[i-1];
                r_pipeLast[i]  <= r_pipeLast[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pe_dot_issue_ctrl.sv
// tb_pe_dot_issue_ctrl
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a job-level reference model: a job is a count of beats to issue,
// each issued beat is scheduled to reappear L cycles later, and credits are
// a plain integer bounded by the slot count.

module tb_pe_dot_issue_ctrl;

    localparam int L    = 3;
    localparam int MAXC = 256;
    localparam int CRED = 4;
    localparam int CW   = $clog2(MAXC);
    localparam int CRW  = $clog2(CRED + 1);

    logic           clock = 1'b0;
    logic           reset;
    logic           i_job_valid;
    logic [CW-1:0]  i_job_chunks_m1;
    logic           o_job_ready;
    logic           i_op_valid;
    logic           o_op_ready;
    logic           o_issue;
    logic           o_issue_first;
    logic           o_issue_last;
    logic           o_mult_valid;
    logic           o_mult_first;
    logic           o_mult_last;
    logic           i_credit_return;
    logic [CRW-1:0] o_credits;
    logic           o_busy;
    logic           o_err;

    always #5 clock = ~clock;

    pe_dot_issue_ctrl #(
        .DOT_LATENCY(L),
        .MAX_CHUNKS (MAXC),
        .CREDITS    (CRED)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .i_job_valid    (i_job_valid),
        .i_job_chunks_m1(i_job_chunks_m1),
        .o_job_ready    (o_job_ready),
        .i_op_valid     (i_op_valid),
        .o_op_ready     (o_op_ready),
        .o_issue        (o_issue),
        .o_issue_first  (o_issue_first),
        .o_issue_last   (o_issue_last),
        .o_mult_valid   (o_mult_valid),
        .o_mult_first   (o_mult_first),
        .o_mult_last    (o_mult_last),
        .i_credit_return(i_credit_return),
        .o_credits      (o_credits),
        .o_busy         (o_busy),
        .o_err          (o_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    bit       mRun;
    int       mTotal;
    int       mCnt;
    int       mCredits;
    bit       mErr;
    bit [2:0] hist [0:8191];

    // Expected values for the current cycle
    bit       eJobReady, eOpReady, eIssue, eFirst, eLast, eBusy;
    bit [2:0] eMult;

    task automatic checkSig(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkSig("job_ready",  8'(o_job_ready),   8'(eJobReady));
        checkSig("op_ready",   8'(o_op_ready),    8'(eOpReady));
        checkSig("issue",      8'(o_issue),       8'(eIssue));
        checkSig("issue_first",8'(o_issue_first), 8'(eFirst));
        checkSig("issue_last", 8'(o_issue_last),  8'(eLast));
        checkSig("mult_valid", 8'(o_mult_valid),  8'(eMult[2]));
        checkSig("mult_first", 8'(o_mult_first),  8'(eMult[1]));
        checkSig("mult_last",  8'(o_mult_last),   8'(eMult[0]));
        checkSig("credits",    8'(o_credits),     8'(mCredits));
        checkSig("busy",       8'(o_busy),        8'(eBusy));
        checkSig("err",        8'(o_err),         8'(mErr));
    endtask

    task automatic modelReset();
        mRun     = 1'b0;
        mTotal   = 1;
        mCnt     = 0;
        mCredits = CRED;
        mErr     = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare all
    // outputs against the model, advance the model, then let the edge happen.
    task automatic applyStimulus(input bit rst, input bit jv, input int jc, input bit ov, input bit cr);
        bit accept;
        @(negedge clock);
        reset           = rst;
        i_job_valid     = jv;
        i_job_chunks_m1 = CW'(jc);
        i_op_valid      = ov;
        i_credit_return = cr;
        #1;
        eJobReady = !mRun && (mCredits != 0);
        eOpReady  = mRun;
        eIssue    = mRun && ov;
        eFirst    = eIssue && (mCnt == 0);
        eLast     = eIssue && (mCnt == mTotal - 1);
        eMult     = hist[cyc];
        eBusy     = mRun;
        for (int k = 0; k < L; k++) if (hist[cyc + k][2]) eBusy = 1'b1;
        checkOutput();
        if (rst) begin
            modelReset();
            for (int k = 1; k <= L; k++) hist[cyc + k] = 3'b000;
        end else begin
            accept = jv && eJobReady;
            if (eIssue) begin
                hist[cyc + L] = {1'b1, eFirst, eLast};
                mCnt++;
                if (eLast) mRun = 1'b0;
            end
            if (accept) begin
                mRun   = 1'b1;
                mTotal = jc + 1;
                mCnt   = 0;
            end
            if (cr && mCredits == CRED) mErr = 1'b1;
            if (accept && !cr) mCredits--;
            else if (cr && !accept && mCredits < CRED) mCredits++;
        end
        @(posedge clock);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        i_job_valid     = 1'b0;
        i_job_chunks_m1 = '0;
        i_op_valid      = 1'b0;
        i_credit_return = 1'b0;
        modelReset();
        repeat (2) @(posedge clock);

        $display("[TB] four-chunk job with continuous operands");
        applyStimulus(0, 1, 3, 1, 0);
        #2 checkSig("dir_credits_after_accept", 8'(o_credits), 8'd3);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0);
        idle(5);
        #2 checkSig("dir_busy_drained", 8'(o_busy), 8'd0);

        $display("[TB] single-chunk job");
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        idle(4);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] credit exhaustion");
        for (int j = 0; j < 4; j++) begin
            applyStimulus(0, 1, 0, 0, 0);
            applyStimulus(0, 0, 0, 1, 0);
        end
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        #2 checkSig("dir_fifth_job_stalled", 8'(o_job_ready), 8'd0);
        applyStimulus(0, 1, 0, 0, 1);
        #2 checkSig("dir_ready_after_return", 8'(o_job_ready), 8'd1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] gapped operand stream");
        applyStimulus(0, 1, 2, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        idle(5);

        $display("[TB] simultaneous accept and return, over-return");
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 1);
        #2 checkSig("dir_credits_cancel", 8'(o_credits), 8'd2);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        #2 checkSig("dir_err_set", 8'(o_err), 8'd1);
        idle(3);
        #2 checkSig("dir_err_sticky", 8'(o_err), 8'd1);
        #0 checkSig("dir_credits_saturated", 8'(o_credits), 8'd4);

        $display("[TB] reset in the middle of a job");
        applyStimulus(0, 1, 5, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        #2 checkSig("dir_reset_credits", 8'(o_credits), 8'd4);
        #0 checkSig("dir_reset_err", 8'(o_err), 8'd0);
        #0 checkSig("dir_reset_op_ready", 8'(o_op_ready), 8'd0);
        idle(5);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            bit rst, jv, ov, cr;
            int jc;
            rst = ($urandom_range(0, 399) == 0);
            jv  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) jc = int'($urandom_range(8, 40));
            else                            jc = int'($urandom_range(0, 5));
            ov  = ($urandom_range(0, 3) != 0);
            cr  = (mCredits < CRED) && ($urandom_range(0, 3) == 0);
            applyStimulus(rst, jv, jc, ov, cr);
        end
        idle(L + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
